os_array_to_ofifo_fsm: RTL and testbench
========================================

Name: os_array_to_ofifo_fsm

Overview:
Drain side of the output-stationary systolic array. It collects the per-column partial sums that the array shifts out after the issue FSM pulses its staggered shift_psum chain. Each column feeds its own small lane FIFO, which removes the column skew. Once every lane holds an entry, the block pops one aligned row and writes it to the psum SRAM at base address plus row index, until len_onij rows of a tile have been written.

Parameters:
psum_bw, 16, width of one column psum
col, 8, number of array columns (OC)
depth, 8, entries per column lane FIFO; power of 2, >=2
addr_width, 8, psum SRAM address width
len_onij, 16, rows (output pixels) per tile

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
array_psum_i  input  psum_bw*col  column c psum at bits [c*psum_bw +: psum_bw]
array_valid_i  input  col  per-column push strobe; column c pushes when bit c=1
start_i  input  1  tile start pulse; samples base_addr_i
base_addr_i  input  addr_width  SRAM address of row 0 of the tile
sram_ready_i  input  1  SRAM accepts a write this cycle
sram_wen_o  output  1  write strobe, registered
sram_addr_o  output  addr_width  write address, registered
sram_data_o  output  psum_bw*col  aligned row, same packing as array_psum_i, registered
busy_o  output  1  high while state != IDLE
tile_done_o  output  1  one-cycle pulse, coincident with the final row's sram_wen_o
overflow_o  output  1  sticky lane-overflow flag

Behaviour:
- One clock, clk. Reset is synchronous and active-high on `reset`.
- Reset: state IDLE, all lanes empty, row_cnt=0, base_q=0. sram_wen_o=0, sram_addr_o=0, sram_data_o=0, busy_o=0, tile_done_o=0, overflow_o=0. Reset mid-tile discards all lane contents; no write is issued in the following cycle.
- Lanes:
  - col independent FIFOs, depth entries each, count width log2(depth)+1.
  - Pushes are accepted in every state, including IDLE, so the array may run ahead of start_i.
  - A push into a full lane without a same-cycle pop is dropped and sets overflow_o. overflow_o is cleared only by reset.
  - Push and pop on the same lane in the same cycle (including a full lane): both take effect; count unchanged; no overflow.
  - Read and write pointers wrap modulo depth.
- pop condition: state==RUN && all lanes non-empty (registered counts) && sram_ready_i. A pop removes the head of every lane simultaneously.
- Latency: a column pushed at cycle t counts as non-empty at t+1. If it completes a row, pop happens at t+1 and sram_wen_o/addr/data are valid at t+2. Minimum push-to-write latency is 2 cycles.
- Output registers on pop:
  - sram_wen_o=1.
  - sram_data_o = concatenated lane heads.
  - sram_addr_o = base_q + row_cnt, modulo 2^addr_width (wraps).
  - sram_data_o and sram_addr_o hold their last value when sram_wen_o=0.
- FSM:
  - IDLE: on start_i, latch base_q=base_addr_i, row_cnt=0, go to RUN.
  - RUN: on each pop, row_cnt++. The pop with row_cnt==len_onij-1 also registers tile_done_o=1 and goes to DONE.
  - DONE: one cycle, then back to IDLE. tile_done_o and the final sram_wen_o are high in this cycle.
  - start_i is ignored outside IDLE.
- busy_o is combinational from state (state != IDLE).
- sram_ready_i low stalls pops. Lanes keep accepting pushes until full, then overflow. Order is preserved on resume.
- Columns are never reordered. Lane heads are always from the same row provided the array pushes each column exactly once per row.

Test Plan:
1. Aligned rows (len_onij=4): reset, start_i with base_addr_i=0x10, then 4 cycles of array_valid_i=8'hFF with column c of row r = r*16+c.
   Required: sram_wen_o high on 4 consecutive cycles, starting 2 cycles after the first push; addresses 0x10..0x13; data matches; tile_done_o with the 4th write; busy_o falls one cycle later.
2. Staggered skew: column c valid at cycle t+c for c=0..7, row value 0xA0+c.
   Required: exactly one write at t+9 with the correct row; no write earlier.
3. Backpressure: sram_ready_i=0 while pushing 3 full rows, then sram_ready_i=1.
   Required: no writes while low; then 3 consecutive writes in push order; overflow_o=0.
4. Overflow: push depth+1 entries on column 0 only.
   Required: overflow_o=1 from the cycle after the 9th push and stays 1; no writes; after 8 rows are completed on the other columns, data equals the first 8 column-0 values.
5. Address wrap: base_addr_i=0xFE, len_onij=4.
   Required: write addresses 0xFE, 0xFF, 0x00, 0x01; tile_done_o on the 0x01 write.
6. Reset mid-tile: assert reset after 2 of 4 rows.
   Required: the next cycle shows all outputs at 0 and state IDLE. A new start_i with 4 fresh rows writes rows 0..3 from the new base, with no stale data.

Source files
------------

// File: rtl/os_array_to_ofifo_fsm.sv
// os_array_to_ofifo_fsm
//   Drain side of the output-stationary systolic array. Each array column
//   pushes its partial sums into a private lane FIFO, which absorbs the
//   column-to-column skew of the staggered shift chain. Once every lane
//   holds at least one entry, one aligned row is popped from all lanes at
//   once and written to the psum SRAM at base address + row index. After
//   len_onij rows, the tile is complete.
//
// Handshake: a row is popped (and a write issued on the following cycle)
//   only when state==RUN, every lane count is non-zero, and sram_ready_i=1.
//   The array side has no ready. A push into a full lane that is not popped
//   in the same cycle is dropped and raises the sticky overflow_o flag.
//
// Ports
//   clk, reset       clock, synchronous active-high reset
//   array_psum_i     column c psum at bits [c*psum_bw +: psum_bw]
//   array_valid_i    per-column push strobe
//   start_i          tile start pulse (IDLE only), samples base_addr_i
//   base_addr_i      SRAM address of row 0 of the tile
//   sram_ready_i     SRAM accepts a write this cycle
//   sram_wen_o       registered write strobe
//   sram_addr_o      registered write address (holds when idle)
//   sram_data_o      registered aligned row (holds when idle)
//   busy_o           state != IDLE
//   tile_done_o      pulse coincident with the final row's write
//   overflow_o       sticky lane-overflow flag
//   state_o          FSM state for debug (0 IDLE, 1 RUN, 2 DONE)
module os_array_to_ofifo_fsm #(
  parameter int psum_bw    = 16,
  parameter int col        = 8,
  parameter int depth      = 8,
  parameter int addr_width = 8,
  parameter int len_onij   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [psum_bw*col-1:0]    array_psum_i,
  input  logic [col-1:0]            array_valid_i,
  input  logic                      start_i,
  input  logic [addr_width-1:0]     base_addr_i,
  input  logic                      sram_ready_i,
  output logic                      sram_wen_o,
  output logic [addr_width-1:0]     sram_addr_o,
  output logic [psum_bw*col-1:0]    sram_data_o,
  output logic                      busy_o,
  output logic                      tile_done_o,
  output logic                      overflow_o,
  output logic [1:0]                state_o
);

  localparam int PW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = PW + 1;
  localparam int RW = (len_onij > 1) ? $clog2(len_onij) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [RW-1:0]         row_cnt;
  logic [addr_width-1:0] base_q;

  logic [psum_bw-1:0]    mem    [col][depth];
  logic [PW-1:0]         wr_ptr [col];
  logic [PW-1:0]         rd_ptr [col];
  logic [CW-1:0]         cnt    [col];

  logic [col-1:0]         lane_ne;
  logic [col-1:0]         push_ok;
  logic [col-1:0]         drop;
  logic [psum_bw*col-1:0] heads;
  logic                   pop;

  // Pop decision uses registered counts only, so a push becomes visible
  // to the pop logic one cycle later.
  always_comb begin
    lane_ne = '0;
    heads   = '0;
    for (int c = 0; c < col; c++) begin
      lane_ne[c]                    = (cnt[c] != '0);
      heads[c*psum_bw +: psum_bw]   = mem[c][rd_ptr[c]];
    end
    pop = (state == RUN) && (&lane_ne) && sram_ready_i;
  end

  // A full lane still accepts a push when it is popped in the same cycle.
  always_comb begin
    push_ok = '0;
    drop    = '0;
    for (int c = 0; c < col; c++) begin
      push_ok[c] = array_valid_i[c] && ((cnt[c] != CW'(depth)) || pop);
      drop[c]    = array_valid_i[c] && !push_ok[c];
    end
  end

  // Lane FIFOs. Storage is not reset; only pointers and counts are.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < col; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        cnt[c]    <= '0;
      end
      overflow_o <= 1'b0;
    end else begin
      for (int c = 0; c < col; c++) begin
        if (push_ok[c]) begin
          mem[c][wr_ptr[c]] <= array_psum_i[c*psum_bw +: psum_bw];
          wr_ptr[c]         <= wr_ptr[c] + PW'(1);
        end
        if (pop) begin
          rd_ptr[c] <= rd_ptr[c] + PW'(1);
        end
        if (push_ok[c] && !pop) begin
          cnt[c] <= cnt[c] + CW'(1);
        end else if (!push_ok[c] && pop) begin
          cnt[c] <= cnt[c] - CW'(1);
        end
      end
      if (|drop) begin
        overflow_o <= 1'b1;
      end
    end
  end

  // Control FSM with registered SRAM-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      row_cnt     <= '0;
      base_q      <= '0;
      sram_wen_o  <= 1'b0;
      sram_addr_o <= '0;
      sram_data_o <= '0;
      tile_done_o <= 1'b0;
    end else begin
      sram_wen_o  <= pop;
      tile_done_o <= 1'b0;
      if (pop) begin
        sram_data_o <= heads;
        // Address arithmetic wraps modulo 2^addr_width.
        sram_addr_o <= base_q + addr_width'(row_cnt);
      end
      case (state)
        IDLE: begin
          if (start_i) begin
            base_q  <= base_addr_i;
            row_cnt <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (pop) begin
            if (row_cnt == RW'(len_onij - 1)) begin
              tile_done_o <= 1'b1;
              row_cnt     <= '0;
              state       <= DONE;
            end else begin
              row_cnt <= row_cnt + RW'(1);
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o  = (state != IDLE);
  assign state_o = state;

endmodule

// File: tb/tb_os_array_to_ofifo_fsm.sv
// Bench for os_array_to_ofifo_fsm. A queue-based reference model advances
// on each rising edge from the applied inputs and pushes every expected
// SRAM write into exp_q; a monitor on the falling edge pops and compares
// whenever a write is due, and checks the status outputs every cycle.
module tb_os_array_to_ofifo_fsm;

  localparam int PB  = 16;
  localparam int COL = 8;
  localparam int DEP = 8;
  localparam int AW  = 8;
  localparam int LEN = 4;
  localparam int DW  = PB * COL;
  localparam int EW  = AW + DW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b1;
  logic [DW-1:0]     array_psum = '0;
  logic [COL-1:0]    array_valid = '0;
  logic              start = 1'b0;
  logic [AW-1:0]     base_addr = '0;
  logic              sram_ready = 1'b1;
  logic              sram_wen;
  logic [AW-1:0]     sram_addr;
  logic [DW-1:0]     sram_data;
  logic              busy;
  logic              tile_done;
  logic              overflow;
  logic [1:0]        state_dbg;

  os_array_to_ofifo_fsm #(
    .psum_bw(PB), .col(COL), .depth(DEP), .addr_width(AW), .len_onij(LEN)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .array_psum_i (array_psum),
    .array_valid_i(array_valid),
    .start_i      (start),
    .base_addr_i  (base_addr),
    .sram_ready_i (sram_ready),
    .sram_wen_o   (sram_wen),
    .sram_addr_o  (sram_addr),
    .sram_data_o  (sram_data),
    .busy_o       (busy),
    .tile_done_o  (tile_done),
    .overflow_o   (overflow),
    .state_o      (state_dbg)
  );

  // ---------------- reference model ----------------
  logic [EW-1:0] exp_q[$];
  logic [PB-1:0] lane_q[COL][$];
  int            cyc = 0;
  int            m_phase = 0;   // 0 idle, 1 collecting rows, 2 done cycle
  int            m_next;
  int            m_row = 0;
  logic [AW-1:0] m_base = '0;
  bit            m_ovf = 1'b0;
  logic [AW-1:0] m_last_addr = '0;
  logic [DW-1:0] m_last_data = '0;
  bit            all_ne;
  logic [DW-1:0] m_rowdata;
  logic [AW-1:0] m_addr;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      for (int c = 0; c < COL; c++) lane_q[c].delete();
      exp_q.delete();
      m_phase = 0; m_row = 0; m_base = '0; m_ovf = 1'b0;
      m_last_addr = '0; m_last_data = '0;
    end else begin
      all_ne = 1'b1;
      for (int c = 0; c < COL; c++) if (lane_q[c].size() == 0) all_ne = 1'b0;
      m_next = (m_phase == 2) ? 0 : m_phase;
      if (m_phase == 1 && all_ne && sram_ready) begin
        for (int c = 0; c < COL; c++) m_rowdata[c*PB +: PB] = lane_q[c].pop_front();
        m_addr = m_base + AW'(m_row);
        exp_q.push_back({m_addr, m_rowdata, (m_row == LEN - 1)});
        m_last_addr = m_addr;
        m_last_data = m_rowdata;
        if (m_row == LEN - 1) begin
          m_row = 0;
          m_next = 2;
        end else begin
          m_row++;
        end
      end
      if (m_phase == 0 && start) begin
        m_base = base_addr;
        m_row = 0;
        m_next = 1;
      end
      // Pushes come after the pop, so a popped full lane has room again.
      for (int c = 0; c < COL; c++) begin
        if (array_valid[c]) begin
          if (lane_q[c].size() < DEP) lane_q[c].push_back(array_psum[c*PB +: PB]);
          else m_ovf = 1'b1;
        end
      end
      m_phase = m_next;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  logic [EW-1:0] ent;
  bit            exp_wen;

  always @(negedge clk) begin
    if (cyc > 0) begin
      exp_wen = (exp_q.size() > 0);
      chk("sram_wen", DW'(sram_wen), DW'(exp_wen));
      if (exp_wen) begin
        ent = exp_q.pop_front();
        chk("sram_addr", DW'(sram_addr), DW'(ent[EW-1 -: AW]));
        chk("sram_data", sram_data, ent[DW:1]);
        chk("tile_done", DW'(tile_done), DW'(ent[0]));
      end else begin
        chk("tile_done_idle", DW'(tile_done), '0);
        chk("addr_hold", DW'(sram_addr), DW'(m_last_addr));
        chk("data_hold", sram_data, m_last_data);
      end
      chk("busy", DW'(busy), DW'(m_phase != 0));
      chk("overflow", DW'(overflow), DW'(m_ovf));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [COL-1:0] v, input logic [DW-1:0] d,
                       input bit st, input logic [AW-1:0] b, input bit rdy);
    array_valid = v;
    array_psum  = d;
    start       = st;
    base_addr   = b;
    sram_ready  = rdy;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, '0, 1'b0, '0, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  function automatic logic [DW-1:0] row_val(input int r, input int off);
    logic [DW-1:0] d;
    for (int c = 0; c < COL; c++) d[c*PB +: PB] = PB'(off + r * 16 + c);
    return d;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clk);
    do_reset();

    // Aligned rows from base 0x10.
    drive('0, '0, 1'b1, 8'h10, 1'b1);
    for (int r = 0; r < 4; r++) drive(8'hFF, row_val(r, 0), 1'b0, '0, 1'b1);
    idle(5);

    // Staggered column skew, then three aligned rows to finish the tile.
    drive('0, '0, 1'b1, 8'h20, 1'b1);
    for (int k = 0; k < COL; k++) drive(COL'(1) << k, row_val(0, 'hA0 - 0), 1'b0, '0, 1'b1);
    idle(3);
    for (int r = 1; r < 4; r++) drive(8'hFF, row_val(r, 'h200), 1'b0, '0, 1'b1);
    idle(5);

    // Backpressure: three rows held back, then released.
    drive('0, '0, 1'b1, 8'h30, 1'b0);
    for (int r = 0; r < 3; r++) drive(8'hFF, row_val(r, 'h300), 1'b0, '0, 1'b0);
    idle(2);
    for (int r = 0; r < 3; r++) drive('0, '0, 1'b0, '0, 1'b0);
    drive(8'hFF, row_val(3, 'h300), 1'b0, '0, 1'b1);
    idle(6);

    // Address wrap from 0xFE.
    drive('0, '0, 1'b1, 8'hFE, 1'b1);
    for (int r = 0; r < 4; r++) drive(8'hFF, row_val(r, 'h400), 1'b0, '0, 1'b1);
    idle(5);

    // Reset mid-tile with a partial row pending, then a fresh tile.
    drive('0, '0, 1'b1, 8'h40, 1'b1);
    for (int r = 0; r < 2; r++) drive(8'hFF, row_val(r, 'h500), 1'b0, '0, 1'b1);
    drive(8'h0F, row_val(2, 'h500), 1'b0, '0, 1'b1);
    do_reset();
    drive('0, '0, 1'b1, 8'h50, 1'b1);
    for (int r = 0; r < 4; r++) drive(8'hFF, row_val(r, 'h600), 1'b0, '0, 1'b1);
    idle(5);

    // Overflow: nine pushes on column 0 while idle, then rows on the rest.
    for (int i = 0; i < DEP + 1; i++) drive(8'h01, row_val(i, 'h700), 1'b0, '0, 1'b1);
    idle(2);
    drive('0, '0, 1'b1, 8'h60, 1'b1);
    for (int r = 0; r < 8; r++) drive(8'hFE, row_val(r, 'h800), 1'b0, '0, 1'b1);
    idle(4);
    drive('0, '0, 1'b1, 8'h70, 1'b1);
    idle(8);
    do_reset();

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      logic [COL-1:0] v;
      logic [DW-1:0]  d;
      v = ($urandom_range(0, 1) == 1) ? 8'hFF : COL'($urandom);
      for (int c = 0; c < COL; c++) d[c*PB +: PB] = PB'($urandom);
      if ($urandom_range(0, 3) == 0) v = '0;
      drive(v, d, ($urandom_range(0, 7) == 0), AW'($urandom),
            ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 299) == 0) do_reset();
    end
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
